// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the force-LUT configuration loader and the PE LUT.
package lut_cfg_pkg;

    localparam int unsigned LUT_SEG_BITS      = 8;
    localparam int unsigned LUT_DEPTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush
    } lut_cfg_state_t;

endpackage

// File: rtl/lut_cfg_loader_if.sv
// Host/DMA segment stream: one (base, slope) pair per accepted beat, Q4.12 signed.
interface lut_cfg_loader_if;

    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_base;
    logic signed [15:0] s_slope;

    modport master (
        output s_valid,
        output s_base,
        output s_slope,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_base,
        input  s_slope,
        output s_ready
    );

endinterface

// File: rtl/lut_cfg_loader.sv
// Streams host (base, slope) pairs into consecutive force-LUT entries, holding off the PE
// array while a load runs and reporting done, a sticky error and a 16-bit checksum.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int unsigned SEG_BITS  = LUT_SEG_BITS,
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEG_BITS-1:0] start_addr,
    input  logic [SEG_BITS:0]   num_entries,
    input  logic                abort,
    lut_cfg_loader_if.slave     host,
    output logic                conf_wr_en,
    output logic [SEG_BITS-1:0] conf_addr,
    output logic signed [15:0]  conf_data_base,
    output logic signed [15:0]  conf_data_slope,
    output logic                busy,
    output logic                pe_hold,
    output logic                done,
    output logic                err,
    output logic [15:0]         checksum
);

    localparam logic [SEG_BITS:0] MAX_ENTRIES = (SEG_BITS + 1)'(LUT_DEPTH);

    lut_cfg_state_t      state_q, state_d;
    logic [SEG_BITS-1:0] addr_q, addr_d;
    logic [SEG_BITS:0]   remain_q, remain_d;
    logic [15:0]         checksum_q, checksum_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [SEG_BITS-1:0] wr_addr_q, wr_addr_d;
    logic signed [15:0]  base_q, base_d;
    logic signed [15:0]  slope_q, slope_d;

    logic load_ready;
    logic beat;

    // Abort takes priority over a simultaneous beat, so ready drops combinationally.
    assign load_ready   = (state_q == StLoad) && !abort;
    assign beat         = host.s_valid && load_ready;
    assign host.s_ready = load_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        base_d     = base_q;
        slope_d    = slope_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_entries == '0 || num_entries > MAX_ENTRIES) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d     = start_addr;
                        remain_d   = num_entries;
                        checksum_d = '0;
                        err_d      = 1'b0;
                        state_d    = StLoad;
                    end
                end
            end
            StLoad: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (beat) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_q;
                    base_d     = host.s_base;
                    slope_d    = host.s_slope;
                    addr_d     = addr_q + SEG_BITS'(1);
                    remain_d   = remain_q - (SEG_BITS + 1)'(1);
                    checksum_d = checksum_q + host.s_base + host.s_slope;
                    if (remain_q == (SEG_BITS + 1)'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            base_q     <= '0;
            slope_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            base_q     <= base_d;
            slope_q    <= slope_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign pe_hold         = busy;
    assign done            = done_q;
    assign err             = err_q;
    assign checksum        = checksum_q;
    assign conf_wr_en      = wr_en_q;
    assign conf_addr       = wr_addr_q;
    assign conf_data_base  = base_q;
    assign conf_data_slope = slope_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed + randomized bench for lut_cfg_loader; expectations come from a queue-based model.
module tb_lut_cfg_loader;
    import lut_cfg_pkg::*;

    localparam int unsigned SB    = LUT_SEG_BITS;
    localparam int unsigned DEPTH = LUT_DEPTH_DEFAULT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SB-1:0] start_addr = '0;
    logic [SB:0]   num_entries = '0;
    logic          abort = 1'b0;
    logic          conf_wr_en;
    logic [SB-1:0] conf_addr;
    logic [15:0]   conf_data_base;
    logic [15:0]   conf_data_slope;
    logic          busy;
    logic          pe_hold;
    logic          done;
    logic          err;
    logic [15:0]   checksum;

    lut_cfg_loader_if hif ();

    lut_cfg_loader #(
        .SEG_BITS  (SB),
        .LUT_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_addr      (start_addr),
        .num_entries     (num_entries),
        .abort           (abort),
        .host            (hif),
        .conf_wr_en      (conf_wr_en),
        .conf_addr       (conf_addr),
        .conf_data_base  (conf_data_base),
        .conf_data_slope (conf_data_slope),
        .busy            (busy),
        .pe_hold         (pe_hold),
        .done            (done),
        .err             (err),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity, logged at the falling edge.
    int          wr_cyc[$];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_base[$];
    logic [15:0] wr_slope[$];
    int          beat_cyc[$];
    int          done_cyc[$];
    // Model: data the bench presented as beats that must be accepted.
    logic [15:0] exp_b[$];
    logic [15:0] exp_s[$];

    always @(negedge clk) begin
        if (conf_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(conf_addr);
            wr_base.push_back(conf_data_base);
            wr_slope.push_back(conf_data_slope);
        end
        if (hif.s_valid && hif.s_ready) beat_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_addr.delete(); wr_base.delete(); wr_slope.delete();
        beat_cyc.delete(); done_cyc.delete(); exp_b.delete(); exp_s.delete();
    endtask

    task automatic do_start(input int sa, input int n, output int s_cyc);
        start       = 1'b1;
        start_addr  = SB'(sa);
        num_entries = (SB + 1)'(n);
        s_cyc       = cyc;
        tick();
        start       = 1'b0;
    endtask

    task automatic drive_beat(input logic [15:0] b, input logic [15:0] s);
        hif.s_valid = 1'b1;
        hif.s_base  = b;
        hif.s_slope = s;
        exp_b.push_back(b);
        exp_s.push_back(s);
        tick();
        hif.s_valid = 1'b0;
    endtask

    task automatic gap();
        hif.s_valid = 1'b0;
        hif.s_base  = 16'($urandom);
        hif.s_slope = 16'($urandom);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) gap();
    endtask

    function automatic int model_sum(input int n);
        int sum = 0;
        for (int k = 0; k < n; k++) sum = (sum + int'(exp_b[k]) + int'(exp_s[k])) & 'hFFFF;
        return sum;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "/s_ready"}, hif.s_ready, 0);
        chk({tag, "/wr_en"}, conf_wr_en, 0);
        chk({tag, "/addr"}, conf_addr, 0);
        chk({tag, "/base"}, conf_data_base, 0);
        chk({tag, "/slope"}, conf_data_slope, 0);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/pe_hold"}, pe_hold, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/err"}, err, 0);
        chk({tag, "/checksum"}, checksum, 0);
    endtask

    task automatic verify(input string tag, input int sa, input int n, input int exp_done);
        chk({tag, "/nwrites"}, wr_cyc.size(), n);
        for (int k = 0; k < n && k < wr_cyc.size() && k < beat_cyc.size(); k++) begin
            chk($sformatf("%s/addr%0d", tag, k), wr_addr[k], (sa + k) % DEPTH);
            chk($sformatf("%s/data%0d", tag, k), {wr_base[k], wr_slope[k]}, {exp_b[k], exp_s[k]});
            chk($sformatf("%s/lat%0d", tag, k), wr_cyc[k] - beat_cyc[k], 1);
        end
        chk({tag, "/ndone"}, done_cyc.size(), exp_done);
        if (done_cyc.size() == 1 && beat_cyc.size() > 0)
            chk({tag, "/done_lat"}, done_cyc[0] - beat_cyc[beat_cyc.size() - 1], 2);
        chk({tag, "/checksum"}, checksum, model_sum(n));
        chk({tag, "/busy_end"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int sa;
        int n;
        int pat[6] = '{1, 0, 0, 1, 0, 1};

        hif.s_valid = 1'b0;
        hif.s_base  = '0;
        hif.s_slope = '0;

        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Full 256-entry load, base=k, slope=-k.
        clear_logs();
        do_start(0, 256, s);
        chk("full/s_ready", hif.s_ready, 1);
        chk("full/pe_hold", pe_hold, 1);
        for (int k = 0; k < 256; k++) drive_beat(16'(k), 16'(-k));
        idle(4);
        verify("full", 0, 256, 1);
        if (done_cyc.size() > 0) chk("full/done_cyc", done_cyc[0] - s, 258);
        chk("full/err", err, 0);

        // Wrap-around with random data and gaps.
        clear_logs();
        do_start(254, 4, s);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) gap();
            drive_beat(16'($urandom), 16'($urandom));
        end
        idle(4);
        verify("wrap", 254, 4, 1);

        // Stalled host, valid pattern 1,0,0,1,0,1.
        clear_logs();
        sa = int'($urandom_range(0, DEPTH - 1));
        do_start(sa, 3, s);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall/pe_hold%0d", i), pe_hold, 1);
            if (pat[i] == 1) drive_beat(16'($urandom), 16'($urandom));
            else gap();
        end
        chk("stall/pe_hold_flush", pe_hold, 1);
        idle(4);
        verify("stall", sa, 3, 1);

        // Abort together with a valid 5th beat.
        clear_logs();
        sa = int'($urandom_range(0, DEPTH - 1));
        do_start(sa, 10, s);
        for (int k = 0; k < 4; k++) drive_beat(16'($urandom), 16'($urandom));
        hif.s_valid = 1'b1;
        hif.s_base  = 16'($urandom);
        hif.s_slope = 16'($urandom);
        abort       = 1'b1;
        #1;
        chk("abort/s_ready", hif.s_ready, 0);
        tick();
        abort       = 1'b0;
        hif.s_valid = 1'b0;
        chk("abort/busy", busy, 0);
        chk("abort/pe_hold", pe_hold, 0);
        chk("abort/err", err, 1);
        idle(4);
        verify("abort", sa, 4, 0);
        chk("abort/err_sticky", err, 1);

        // Illegal counts, then a start while busy.
        clear_logs();
        do_start(5, 0, s);
        chk("zero/err", err, 1);
        chk("zero/busy", busy, 0);
        do_start(7, DEPTH + 1, s);
        chk("over/err", err, 1);
        chk("over/busy", busy, 0);
        idle(3);
        chk("illegal/nwrites", wr_cyc.size(), 0);
        chk("illegal/ndone", done_cyc.size(), 0);

        clear_logs();
        do_start(10, 3, s);
        chk("legal/err_cleared", err, 0);
        start       = 1'b1;
        start_addr  = SB'(100);
        num_entries = (SB + 1)'(50);
        drive_beat(16'($urandom), 16'($urandom));
        start = 1'b0;
        drive_beat(16'($urandom), 16'($urandom));
        drive_beat(16'($urandom), 16'($urandom));
        idle(4);
        verify("busy_start", 10, 3, 1);

        // Asynchronous reset after 2 of 5 beats.
        clear_logs();
        do_start(int'($urandom_range(0, DEPTH - 1)), 5, s);
        drive_beat(16'($urandom), 16'($urandom));
        drive_beat(16'($urandom), 16'($urandom));
        chk("midreset/wr_before", conf_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();

        clear_logs();
        sa = int'($urandom_range(0, DEPTH - 1));
        n  = int'($urandom_range(2, 8));
        do_start(sa, n, s);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 1)) gap();
            drive_beat(16'($urandom), 16'($urandom));
        end
        idle(4);
        verify("after_reset", sa, n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
